// File: rtl/bp_byte_fifo.sv
// Byte-wide valid/ready FIFO: a (DEPTH-1)-entry RAM feeding a registered output stage,
// with a bypass into the output register when the RAM is empty.
module bp_byte_fifo #(
   parameter int DEPTH     = 64,
   parameter int HIGHWATER = 56
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic [7:0]                 i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic [7:0]                 o_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH+1)-1:0] o_nEntries,
   output logic                       o_highWater
);

   localparam int CW    = $clog2(DEPTH+1);
   localparam int RAM_D = DEPTH - 1;
   localparam int PW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(RAM_D - 1);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [CW-1:0] HW       = CW'(HIGHWATER);

   logic [7:0]    mem [RAM_D];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [7:0]    data_q;
   logic          valid_q, run, hw_q;
   logic          push, pop, out_free, ram_empty, load_ram, load_byp, ram_wr;

   // Pointers wrap by explicit compare so DEPTH-1 need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign o_ready     = run & (count != FULL) & ~i_flush;
   assign o_valid     = valid_q & ~i_flush;
   assign o_data      = data_q;
   assign o_nEntries  = count;
   assign o_highWater = hw_q;

   assign push      = i_valid & o_ready;
   assign pop       = o_valid & i_ready;
   assign out_free  = ~valid_q | pop;
   // The output register counts as one entry whenever it holds a byte.
   assign ram_empty = (count - CW'(valid_q)) == '0;
   assign load_ram  = out_free & ~ram_empty;
   assign load_byp  = out_free & ram_empty & push;
   assign ram_wr    = push & ~load_byp;
   assign count_nxt = count + CW'(push) - CW'(pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run     <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         hw_q    <= 1'b0;
      end else if (i_flush) begin
         run     <= 1'b1;
         valid_q <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         hw_q    <= 1'b0;
      end else begin
         run   <= 1'b1;
         count <= count_nxt;
         hw_q  <= (count_nxt >= HW);
         if (ram_wr)
            wr_ptr <= next_ptr(wr_ptr);
         if (out_free)
            valid_q <= load_ram | load_byp;
         if (load_ram) begin
            data_q <= mem[rd_ptr];
            rd_ptr <= next_ptr(rd_ptr);
         end else if (load_byp) begin
            data_q <= i_data;
         end
      end
   end

   // Storage array carries no reset; only the pointers define its contents.
   always_ff @(posedge i_clk) begin
      if (ram_wr)
         mem[wr_ptr] <= i_data;
   end

endmodule

// File: tb/tb_bp_byte_fifo.sv
// Scoreboard bench for bp_byte_fifo: accepted bytes queue up, a monitor checks each popped byte.
module tb_bp_byte_fifo;

   localparam int DEPTH = 64;
   localparam int HW    = 56;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       flush = 1'b0;
   logic [7:0] din = 8'h00;
   logic       vin = 1'b0;
   logic       rdy_out;
   logic [7:0] dout;
   logic       vout;
   logic       rdy_in = 1'b0;
   logic [6:0] n_entries;
   logic       high_water;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   bp_byte_fifo #(.DEPTH(DEPTH), .HIGHWATER(HW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_data(din), .i_valid(vin), .o_ready(rdy_out),
      .o_data(dout), .o_valid(vout), .i_ready(rdy_in),
      .o_nEntries(n_entries), .o_highWater(high_water)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Input side: every accepted byte becomes an expected output.
   always @(negedge clk) begin
      if (rst_n && vin && rdy_out)
         sb.push_back(din);
   end

   // Output side: every handshake must match the oldest expected byte.
   always @(negedge clk) begin
      if (rst_n && vout && rdy_in) begin
         if (sb.size() == 0) begin
            chk("pop_with_empty_scoreboard", 1, 0);
         end else begin
            chk("pop_data", int'(dout), int'(sb[0]));
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      int budget;

      // Reset state
      #1 rst_n = 1'b0;
      #20;
      chk("rst_valid", int'(vout), 0);
      chk("rst_ready", int'(rdy_out), 0);
      chk("rst_count", int'(n_entries), 0);
      chk("rst_hw", int'(high_water), 0);
      chk("rst_data", int'(dout), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      chk("ready_before_first_edge", int'(rdy_out), 0);
      step();
      chk("ready_after_release", int'(rdy_out), 1);

      // Bypass latency
      rdy_in = 1'b1; vin = 1'b1; din = 8'hA5;
      step();
      vin = 1'b0;
      chk("byp_valid", int'(vout), 1);
      chk("byp_data", int'(dout), 8'hA5);
      chk("byp_count", int'(n_entries), 1);
      step();
      chk("byp_count_after", int'(n_entries), 0);
      chk("byp_valid_after", int'(vout), 0);

      // Fill then drain
      rdy_in = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         vin = 1'b1; din = 8'(i);
         step();
         chk("fill_count", int'(n_entries), i + 1);
         chk("fill_hw", int'(high_water), (i + 1 >= HW) ? 1 : 0);
         chk("fill_ready", int'(rdy_out), (i + 1 != DEPTH) ? 1 : 0);
      end
      vin = 1'b0;
      rdy_in = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         step();
         chk("drain_count", int'(n_entries), DEPTH - 1 - i);
      end
      chk("drain_valid", int'(vout), 0);
      chk("drain_hw", int'(high_water), 0);

      // Streaming with no bubbles
      rdy_in = 1'b1; vin = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         din = 8'(k);
         step();
         chk("stream_count", int'(n_entries), 1);
         chk("stream_valid", int'(vout), 1);
      end
      vin = 1'b0;
      step();
      chk("stream_end_count", int'(n_entries), 0);

      // Full with simultaneous pop, across the pointer wrap
      rdy_in = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         vin = 1'b1; din = 8'(8'h80 + i);
         step();
      end
      chk("full_count", int'(n_entries), DEPTH);
      din = 8'hEE; rdy_in = 1'b1;
      chk("full_ready_low", int'(rdy_out), 0);
      step();
      chk("full_pop_ready", int'(rdy_out), 1);
      chk("full_pop_count", int'(n_entries), DEPTH - 1);
      step();
      vin = 1'b0;
      chk("full_pushpop_count", int'(n_entries), DEPTH - 1);
      budget = 0;
      while (vout && budget < 100) begin
         step();
         budget++;
      end
      chk("full_drain_done", int'(vout), 0);
      chk("full_drain_cycles", budget, DEPTH - 1);
      chk("full_drain_sb_empty", sb.size(), 0);

      // Flush
      rdy_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         vin = 1'b1; din = 8'(8'h10 + i);
         step();
      end
      chk("flush_pre_count", int'(n_entries), 10);
      flush = 1'b1; vin = 1'b1; din = 8'h99; rdy_in = 1'b1;
      #1;
      chk("flush_valid_low", int'(vout), 0);
      chk("flush_ready_low", int'(rdy_out), 0);
      step();
      flush = 1'b0;
      sb.delete();
      chk("flush_count", int'(n_entries), 0);
      chk("flush_valid", int'(vout), 0);
      chk("flush_hw", int'(high_water), 0);
      vin = 1'b1; din = 8'h42;
      step();
      vin = 1'b0;
      chk("flush_first_data", int'(dout), 8'h42);
      chk("flush_first_valid", int'(vout), 1);
      step();
      chk("flush_end_count", int'(n_entries), 0);

      // Asynchronous reset mid-stream
      rdy_in = 1'b0;
      for (int i = 0; i < 20; i++) begin
         vin = 1'b1; din = 8'(8'h60 + i);
         step();
      end
      vin = 1'b0;
      chk("arst_pre_count", int'(n_entries), 20);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(vout), 0);
      chk("arst_ready", int'(rdy_out), 0);
      chk("arst_count", int'(n_entries), 0);
      sb.delete();
      step();
      rst_n = 1'b1;
      rdy_in = 1'b1;
      step();
      chk("arst_ready_after", int'(rdy_out), 1);
      chk("arst_valid_after", int'(vout), 0);
      chk("arst_count_after", int'(n_entries), 0);
      vin = 1'b1; din = 8'h37;
      step();
      vin = 1'b0;
      chk("arst_first_data", int'(dout), 8'h37);
      step();
      step();
      chk("arst_no_stale", int'(vout), 0);
      chk("final_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/bp_byte_fifo.md
# bp_byte_fifo

Byte-wide valid/ready FIFO between the USB full-speed serial device's host-to-device byte stream and the bytepipe register/correlator input. It absorbs USB packet bursts (up to wMaxPacketSize bytes per OUT transaction) while the correlator is busy. It also reports occupancy and a high-water flag, which let the top level throttle NAKs or drive a debug LED. One instance per direction is permitted; the devToHost direction uses the same block unchanged.

## Interface
- DEPTH, 64, number of byte entries, 2..256, any integer (need not be a power of two).
- HIGHWATER, 56, o_highWater threshold in entries, 1..DEPTH.
- i_clk  input  1  single clock (48MHz in the correlator build); all logic on rising edge.
- i_rst_n  input  1  reset, asynchronous assertion, active-low.
- i_flush  input  1  synchronous flush; discards all contents.
- i_data  input  8  upstream byte.
- i_valid  input  1  upstream byte valid.
- o_ready  output  1  FIFO can accept a byte this cycle.
- o_data  output  8  downstream byte, registered.
- o_valid  output  1  o_data valid, registered.
- i_ready  input  1  downstream accepts o_data.
- o_nEntries  output  $clog2(DEPTH+1)  bytes held, including the output register.
- o_highWater  output  1  o_nEntries >= HIGHWATER, registered.

## Operation
- Push = i_valid & o_ready. Pop = o_valid & i_ready. Both may occur in the same cycle.
- Storage is a DEPTH-1 entry RAM (write/read pointers) plus the o_data output register. Total capacity is DEPTH.
- Write pointer and read pointer wrap from DEPTH-2 to 0 by explicit compare, not by truncation.
- Output register refill:
  - When the output register is empty or popped and RAM is non-empty, load the RAM head.
  - Otherwise, when the output register is empty or popped and a push occurs, load i_data directly (bypass).
- Bytes leave in exactly the order accepted. No byte is duplicated or lost except on flush.
- o_nEntries next = o_nEntries + push - pop. It is never above DEPTH and never below 0.
- o_ready = (o_nEntries != DEPTH) & ~i_flush & rst-released. It depends only on registered state and i_flush; there is no combinational path from i_ready.
  - When full, o_ready is low even if a pop occurs in the same cycle.
- Flush:
  - o_valid and o_ready are forced low in the flush cycle, so no handshakes occur.
  - On the next edge, pointers, count, o_valid and o_highWater are all 0.
- o_data is held stable while o_valid & ~i_ready. It changes only on pop, flush or reset.
- i_data is don't-care when i_valid is low. o_data is don't-care when o_valid is low.

## Timing
- Reset values, held while i_rst_n is low and until the first edge after release:
  - o_valid=0, o_ready=0, o_nEntries=0, o_highWater=0.
  - o_data=8'h00.
  - Pointers are 0.
- After reset release, o_ready=1 in the first cycle.
- Latency:
  - A byte pushed at edge N into an empty FIFO gives o_valid=1 with that byte after edge N (bypass).
  - A byte pushed behind others appears after all earlier bytes are popped.
- Throughput: one push and one pop per cycle sustained, with no bubbles when i_valid and i_ready are held high.
- Full boundary:
  - With o_nEntries=DEPTH-1, a push with no pop makes o_ready=0 after that edge.
  - A pop at full re-asserts o_ready after that edge.
- Empty boundary: with o_nEntries=1, a pop with no push makes o_valid=0 after that edge.
- Simultaneous push and pop leaves o_nEntries unchanged, including at 1, where the bypass path loads the new byte.
- o_highWater updates on the same edge as o_nEntries. Both are registered.
- Reset mid-stream: asynchronous assertion clears o_valid/o_ready immediately. All contents are discarded.

## Test plan
- Fill/drain with DEPTH=64 and i_ready=0: push 0x00..0x3F. After the 64th push, o_ready=0 and o_nEntries=64. o_highWater rises after the 56th push. Set i_ready=1: 0x00..0x3F emerge in order over 64 cycles, then o_valid=0 and o_nEntries=0.
- Bypass latency: on an empty FIFO, push 0xA5 at edge N with i_ready=1. o_valid=1 and o_data=0xA5 in cycle N+1; popped at edge N+1; o_nEntries returns to 0.
- Streaming: drive i_valid=i_ready=1 for 1000 cycles with an incrementing byte. The output sequence is identical, with no bubbles, and o_nEntries stays at 1.
- Full with simultaneous pop: fill to 64, then drive i_valid=1 and i_ready=1. No push in the full cycle, one pop. The next cycle has o_ready=1 and o_nEntries=63. Ordering holds across the pointer wrap at index 62→0.
- Flush: hold 10 bytes, assert i_flush for 1 cycle with i_valid=i_ready=1. No handshake that cycle. Afterwards o_nEntries=0 and o_valid=0, and the next pushed byte 0x42 emerges first.
- Async reset mid-stream: hold 20 bytes, pull i_rst_n low between edges. o_valid, o_ready and o_nEntries go to 0 without a clock edge. After release, no stale byte appears.
